// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the RV64 five-stage pipeline.
// Supports stall (hold), flush (bubble) and a saturating bubble counter.
module id_ex_reg #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             validIn,
    input  logic [XLEN-1:0]  pcIn,
    input  logic [XLEN-1:0]  readData1In,
    input  logic [XLEN-1:0]  readData2In,
    input  logic [XLEN-1:0]  immIn,
    input  logic [6:0]       funct7In,
    input  logic [2:0]       funct3In,
    input  logic [4:0]       rs1In,
    input  logic [4:0]       rs2In,
    input  logic [4:0]       rdIn,
    input  logic [1:0]       aluOpIn,
    input  logic             aluSrcIn,
    input  logic             branchIn,
    input  logic             memReadIn,
    input  logic             memWriteIn,
    input  logic             regWriteIn,
    input  logic             memToRegIn,
    output logic             validOut,
    output logic [XLEN-1:0]  pcOut,
    output logic [XLEN-1:0]  readData1Out,
    output logic [XLEN-1:0]  readData2Out,
    output logic [XLEN-1:0]  immOut,
    output logic [6:0]       funct7Out,
    output logic [2:0]       funct3Out,
    output logic [4:0]       rs1Out,
    output logic [4:0]       rs2Out,
    output logic [4:0]       rdOut,
    output logic [1:0]       aluOpOut,
    output logic             aluSrcOut,
    output logic             branchOut,
    output logic             memReadOut,
    output logic             memWriteOut,
    output logic             regWriteOut,
    output logic             memToRegOut,
    output logic [CNT_W-1:0] bubbleCount
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [1:0]      aluOp;
        logic            aluSrc;
        logic            branch;
        logic            memRead;
        logic            memWrite;
        logic            regWrite;
        logic            memToReg;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stage_t           stage_q, stage_d, in_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             insert_bubble;

    always_comb begin
        in_s          = '0;
        in_s.valid    = 1'b1;
        in_s.pc       = pcIn;
        in_s.rd1      = readData1In;
        in_s.rd2      = readData2In;
        in_s.imm      = immIn;
        in_s.funct7   = funct7In;
        in_s.funct3   = funct3In;
        in_s.rs1      = rs1In;
        in_s.rs2      = rs2In;
        in_s.rd       = rdIn;
        in_s.aluOp    = aluOpIn;
        in_s.aluSrc   = aluSrcIn;
        in_s.branch   = branchIn;
        in_s.memRead  = memReadIn;
        in_s.memWrite = memWriteIn;
        in_s.regWrite = regWriteIn;
        in_s.memToReg = memToRegIn;
    end

    // An invalid ID slot is treated exactly like a flush: all-zero bubble.
    assign insert_bubble = flush | (~stall & ~validIn);

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (insert_bubble) begin
            stage_d = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (!stall) begin
            stage_d = in_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign validOut     = stage_q.valid;
    assign pcOut        = stage_q.pc;
    assign readData1Out = stage_q.rd1;
    assign readData2Out = stage_q.rd2;
    assign immOut       = stage_q.imm;
    assign funct7Out    = stage_q.funct7;
    assign funct3Out    = stage_q.funct3;
    assign rs1Out       = stage_q.rs1;
    assign rs2Out       = stage_q.rs2;
    assign rdOut        = stage_q.rd;
    assign aluOpOut     = stage_q.aluOp;
    assign aluSrcOut    = stage_q.aluSrc;
    assign branchOut    = stage_q.branch;
    assign memReadOut   = stage_q.memRead;
    assign memWriteOut  = stage_q.memWrite;
    assign regWriteOut  = stage_q.regWrite;
    assign memToRegOut  = stage_q.memToReg;
    assign bubbleCount  = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, stall, flush,
// invalid-slot bubbles and counter saturation (CNT_W=4).
module tb_id_ex_reg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall, flush, validIn;
    logic [XLEN-1:0]  pcIn, readData1In, readData2In, immIn;
    logic [6:0]       funct7In;
    logic [2:0]       funct3In;
    logic [4:0]       rs1In, rs2In, rdIn;
    logic [1:0]       aluOpIn;
    logic             aluSrcIn, branchIn, memReadIn;
    logic             memWriteIn, regWriteIn, memToRegIn;
    logic             validOut;
    logic [XLEN-1:0]  pcOut, readData1Out, readData2Out, immOut;
    logic [6:0]       funct7Out;
    logic [2:0]       funct3Out;
    logic [4:0]       rs1Out, rs2Out, rdOut;
    logic [1:0]       aluOpOut;
    logic             aluSrcOut, branchOut, memReadOut;
    logic             memWriteOut, regWriteOut, memToRegOut;
    logic [CNT_W-1:0] bubbleCount;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .validIn(validIn), .pcIn(pcIn),
        .readData1In(readData1In), .readData2In(readData2In),
        .immIn(immIn), .funct7In(funct7In), .funct3In(funct3In),
        .rs1In(rs1In), .rs2In(rs2In), .rdIn(rdIn),
        .aluOpIn(aluOpIn), .aluSrcIn(aluSrcIn), .branchIn(branchIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn),
        .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
        .validOut(validOut), .pcOut(pcOut),
        .readData1Out(readData1Out), .readData2Out(readData2Out),
        .immOut(immOut), .funct7Out(funct7Out), .funct3Out(funct3Out),
        .rs1Out(rs1Out), .rs2Out(rs2Out), .rdOut(rdOut),
        .aluOpOut(aluOpOut), .aluSrcOut(aluSrcOut),
        .branchOut(branchOut), .memReadOut(memReadOut),
        .memWriteOut(memWriteOut), .regWriteOut(regWriteOut),
        .memToRegOut(memToRegOut), .bubbleCount(bubbleCount)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_busy();
        validIn = 1'b1; pcIn = 64'hDEAD_0000;
        readData1In = 64'h11; readData2In = 64'h22; immIn = 64'h33;
        funct7In = 7'h7F; funct3In = 3'h7;
        rs1In = 5'd1; rs2In = 5'd2; rdIn = 5'd3; aluOpIn = 2'b10;
        aluSrcIn = 1'b1; branchIn = 1'b1; memReadIn = 1'b1;
        memWriteIn = 1'b1; regWriteIn = 1'b1; memToRegIn = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(validOut), 64'd0);
        check({tag, ".pc"}, pcOut, 64'd0);
        check({tag, ".rd1"}, readData1Out, 64'd0);
        check({tag, ".imm"}, immOut, 64'd0);
        check({tag, ".aluOp"}, 64'(aluOpOut), 64'd0);
        check({tag, ".ctl"}, 64'({aluSrcOut, branchOut, memReadOut,
              memWriteOut, regWriteOut, memToRegOut}), 64'd0);
        check({tag, ".rd"}, 64'(rdOut), 64'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_busy();
        #2;
        check_zero("por");
        check("por.cnt", 64'(bubbleCount), 64'd0);
        rst = 1'b0;
        tick();
        check("busy.valid", 64'(validOut), 64'd1);
        check("busy.pc", pcOut, 64'hDEAD_0000);
        check("busy.ctl", 64'({aluSrcOut, branchOut, memReadOut,
              memWriteOut, regWriteOut, memToRegOut}), 64'h3F);
        // Async reset between edges with all inputs nonzero.
        #2 rst = 1'b1;
        #1;
        check_zero("arst");
        check("arst.cnt", 64'(bubbleCount), 64'd0);
        #1 rst = 1'b0;

        // Normal load.
        validIn = 1'b1; pcIn = 64'h100; readData1In = 64'd5;
        readData2In = 64'd3; immIn = 64'd0; funct7In = 7'b0100000;
        funct3In = 3'b000; aluOpIn = 2'b10; regWriteIn = 1'b1;
        rdIn = 5'd7; rs1In = 5'd4; rs2In = 5'd6; aluSrcIn = 1'b0;
        branchIn = 1'b0; memReadIn = 1'b0; memWriteIn = 1'b0;
        memToRegIn = 1'b0;
        tick();
        check("ld.valid", 64'(validOut), 64'd1);
        check("ld.pc", pcOut, 64'h100);
        check("ld.rd1", readData1Out, 64'd5);
        check("ld.rd2", readData2Out, 64'd3);
        check("ld.f7", 64'(funct7Out), 64'h20);
        check("ld.f3", 64'(funct3Out), 64'd0);
        check("ld.aluOp", 64'(aluOpOut), 64'd2);
        check("ld.regW", 64'(regWriteOut), 64'd1);
        check("ld.rd", 64'(rdOut), 64'd7);
        check("ld.rs", 64'({rs1Out, rs2Out}), 64'({5'd4, 5'd6}));
        check("ld.cnt", 64'(bubbleCount), 64'd0);

        pcIn = 64'h200; readData1In = 64'hABCD; immIn = 64'hFFFF_FFF0;
        aluOpIn = 2'b01; branchIn = 1'b1; regWriteIn = 1'b0;
        tick();
        check("ld2.pc", pcOut, 64'h200);
        check("ld2.rd1", readData1Out, 64'hABCD);
        check("ld2.imm", immOut, 64'hFFFF_FFF0);
        check("ld2.aluOp", 64'(aluOpOut), 64'd1);
        check("ld2.br", 64'(branchOut), 64'd1);
        check("ld2.regW", 64'(regWriteOut), 64'd0);

        // Stall for three cycles while ID moves on to 0x104.
        pcIn = 64'h100; readData1In = 64'd5; aluOpIn = 2'b10;
        branchIn = 1'b0; regWriteIn = 1'b1;
        tick();
        check("pre.pc", pcOut, 64'h100);
        stall = 1'b1; pcIn = 64'h104; readData1In = 64'd99;
        validIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.pc", pcOut, 64'h100);
            check("stall.valid", 64'(validOut), 64'd1);
            check("stall.rd1", readData1Out, 64'd5);
            check("stall.cnt", 64'(bubbleCount), 64'd0);
        end
        stall = 1'b0; validIn = 1'b1;
        tick();
        check("rel.pc", pcOut, 64'h104);
        check("rel.rd1", readData1Out, 64'd99);

        // Flush wins over stall.
        memWriteIn = 1'b1; stall = 1'b1; flush = 1'b1;
        tick();
        check_zero("fl");
        check("fl.rd2", readData2Out, 64'd0);
        check("fl.cnt", 64'(bubbleCount), 64'd1);
        stall = 1'b0; flush = 1'b0;

        // Invalid ID slot for two edges.
        validIn = 1'b0; regWriteIn = 1'b1;
        tick();
        check("inv1.regW", 64'(regWriteOut), 64'd0);
        check("inv1.valid", 64'(validOut), 64'd0);
        check("inv1.cnt", 64'(bubbleCount), 64'd2);
        tick();
        check("inv2.regW", 64'(regWriteOut), 64'd0);
        check("inv2.valid", 64'(validOut), 64'd0);
        check("inv2.cnt", 64'(bubbleCount), 64'd3);

        // Stalled bubble does not count.
        stall = 1'b1;
        tick();
        check("stb.cnt", 64'(bubbleCount), 64'd3);
        stall = 1'b0;

        // Saturation of the 4-bit counter.
        validIn = 1'b1; flush = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("sat.cnt", 64'(bubbleCount),
                  (3 + i > 15) ? 64'd15 : 64'(3 + i));
        end
        check("sat.valid", 64'(validOut), 64'd0);

        // Reset mid-flush, then a clean load.
        #2 rst = 1'b1;
        #1;
        check("rfl.cnt", 64'(bubbleCount), 64'd0);
        #1 rst = 1'b0; flush = 1'b0; pcIn = 64'h300;
        tick();
        check("post.valid", 64'(validOut), 64'd1);
        check("post.pc", pcOut, 64'h300);
        check("post.cnt", 64'(bubbleCount), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
